// File: rtl/seg_decoder.sv
// Seven-segment loopback monitor: filters and decodes the active-low hex-digit pair back into a byte.
// Optional err_cnt counter is built when SEG_DECODER_ERRCNT_EN is defined; otherwise err_cnt reads 8'h00.
module seg_decoder #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] seg_lo,
    input  logic [7:0] seg_hi,
    input  logic       clr,
    output logic [7:0] byte_o,
    output logic       byte_vld,
    output logic       blank,
    output logic       err,
    output logic       upd,
    output logic [1:0] dp_o,
    output logic [7:0] err_cnt
);

    typedef enum logic [1:0] {
        ST_BLANK,
        ST_SHOW,
        ST_BAD
    } state_t;

    typedef struct packed {
        logic       hex;
        logic       is_blank;
        logic [3:0] nib;
    } digit_t;

    localparam logic [7:0] STABLE_N = 8'(STABLE_CYCLES);

    // The dp bit is masked so the table reads exactly like the encoder's byte table.
    function automatic digit_t decode(input logic [7:0] seg);
        digit_t d;
        d.hex      = 1'b1;
        d.is_blank = 1'b0;
        d.nib      = 4'h0;
        case ({seg[7:1], 1'b0})
            8'h02:   d.nib = 4'h0;
            8'h9E:   d.nib = 4'h1;
            8'h24:   d.nib = 4'h2;
            8'h0C:   d.nib = 4'h3;
            8'h98:   d.nib = 4'h4;
            8'h48:   d.nib = 4'h5;
            8'h40:   d.nib = 4'h6;
            8'h1E:   d.nib = 4'h7;
            8'h00:   d.nib = 4'h8;
            8'h08:   d.nib = 4'h9;
            8'h10:   d.nib = 4'hA;
            8'hC0:   d.nib = 4'hB;
            8'h62:   d.nib = 4'hC;
            8'h84:   d.nib = 4'hD;
            8'h60:   d.nib = 4'hE;
            8'h70:   d.nib = 4'hF;
            8'hFE: begin
                d.hex      = 1'b0;
                d.is_blank = 1'b1;
            end
            default: d.hex = 1'b0;
        endcase
        return d;
    endfunction

    logic [15:0] pair;
    logic [15:0] sample_q, sample_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] committed_q, committed_d;
    state_t      state_q, state_d;
    logic [7:0]  byte_q, byte_d;
    logic        err_q, err_d;
    logic        upd_q, upd_d;
    logic [1:0]  dp_q, dp_d;
    logic        commit;
    logic        bad_commit;
    digit_t      dig_hi, dig_lo;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        pair     = {seg_hi, seg_lo};
        sample_d = pair;
        // A zero count marks "nothing sampled since reset", so the first sample always starts at 1.
        if (pair != sample_q || cnt_q == 8'd0) begin
            cnt_d = 8'd1;
        end else if (cnt_q < STABLE_N) begin
            cnt_d = cnt_q + 8'd1;
        end else begin
            cnt_d = cnt_q;
        end

        dig_hi     = decode(seg_hi);
        dig_lo     = decode(seg_lo);
        commit     = (cnt_d == STABLE_N) && (pair != committed_q);
        bad_commit = 1'b0;

        committed_d = committed_q;
        state_d     = state_q;
        byte_d      = byte_q;
        dp_d        = dp_q;
        upd_d       = commit;
        err_d       = clr ? 1'b0 : err_q;

        if (commit) begin
            committed_d = pair;
            dp_d        = {seg_hi[0], seg_lo[0]};
            if (dig_hi.hex && dig_lo.hex) begin
                state_d = ST_SHOW;
                byte_d  = {dig_hi.nib, dig_lo.nib};
            end else if (dig_hi.is_blank && dig_lo.is_blank) begin
                state_d = ST_BLANK;
            end else begin
                state_d    = ST_BAD;
                err_d      = 1'b1;
                bad_commit = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            sample_q    <= 16'hFFFF;
            cnt_q       <= 8'd0;
            committed_q <= 16'hFFFF;
            state_q     <= ST_BLANK;
            byte_q      <= 8'h00;
            err_q       <= 1'b0;
            upd_q       <= 1'b0;
            dp_q        <= 2'b11;
        end else begin
            sample_q    <= sample_d;
            cnt_q       <= cnt_d;
            committed_q <= committed_d;
            state_q     <= state_d;
            byte_q      <= byte_d;
            err_q       <= err_d;
            upd_q       <= upd_d;
            dp_q        <= dp_d;
        end
    end

    assign byte_o   = byte_q;
    assign byte_vld = (state_q == ST_SHOW);
    assign blank    = (state_q == ST_BLANK);
    assign err      = err_q;
    assign upd      = upd_q;
    assign dp_o     = dp_q;

`ifdef SEG_DECODER_ERRCNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (bad_commit && err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= 8'h00;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    logic unused_bad_commit;
    assign unused_bad_commit = bad_commit;
    assign err_cnt           = 8'h00;
`endif

endmodule

// File: tb/tb_seg_decoder.sv
// Scoreboard bench for seg_decoder: stimulus pushes expected commits, a negedge monitor checks each upd pulse.
module tb_seg_decoder;

    localparam int N = 4;
`ifdef SEG_DECODER_ERRCNT_EN
    localparam bit ERRC = 1'b1;
`else
    localparam bit ERRC = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] seg_lo = 8'hFF;
    logic [7:0] seg_hi = 8'hFF;
    logic       clr = 1'b0;
    logic [7:0] byte_o;
    logic       byte_vld;
    logic       blank;
    logic       err;
    logic       upd;
    logic [1:0] dp_o;
    logic [7:0] err_cnt;

    seg_decoder #(.STABLE_CYCLES(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .seg_lo   (seg_lo),
        .seg_hi   (seg_hi),
        .clr      (clr),
        .byte_o   (byte_o),
        .byte_vld (byte_vld),
        .blank    (blank),
        .err      (err),
        .upd      (upd),
        .dp_o     (dp_o),
        .err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] byte_v;
        logic       vld;
        logic       blk;
        logic       er;
        logic [1:0] dp;
        logic [7:0] cnt;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every upd pulse must match the oldest pending expectation, including its edge number.
    always @(negedge clk) begin
        if (!rst && upd === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("spurious_upd", 32'(upd), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("commit_cycle", 32'(cyc), 32'(e.cyc));
                check("byte_o", 32'(byte_o), 32'(e.byte_v));
                check("byte_vld", 32'(byte_vld), 32'(e.vld));
                check("blank", 32'(blank), 32'(e.blk));
                check("err", 32'(err), 32'(e.er));
                check("dp_o", 32'(dp_o), 32'(e.dp));
                check("err_cnt", 32'(err_cnt), 32'(e.cnt));
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] hi, input logic [7:0] lo);
        seg_hi = hi;
        seg_lo = lo;
    endtask

    task automatic expect_commit(input logic [7:0] b, input logic v, input logic bl,
                                 input logic e, input logic [1:0] dp, input logic [7:0] bad_n);
        exp_t x;
        x.byte_v = b;
        x.vld    = v;
        x.blk    = bl;
        x.er     = e;
        x.dp     = dp;
        x.cnt    = ERRC ? bad_n : 8'h00;
        x.cyc    = cyc + N;
        exp_q.push_back(x);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_byte_o"}, 32'(byte_o), 32'h00);
        check({tag, "_byte_vld"}, 32'(byte_vld), 32'd0);
        check({tag, "_blank"}, 32'(blank), 32'd1);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_upd"}, 32'(upd), 32'd0);
        check({tag, "_dp_o"}, 32'(dp_o), 32'h3);
        check({tag, "_err_cnt"}, 32'(err_cnt), 32'h00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        step(2);
        check_reset("rst");
        rst = 1'b0;

        // 2/F pair, then a long hold that must not re-pulse upd.
        drive(8'h24, 8'h70);
        expect_commit(8'h2F, 1'b1, 1'b0, 1'b0, 2'b00, 8'd0);
        step(12);

        // Low digit toggles faster than the filter, then settles on "1".
        drive(8'h24, 8'h02); step(3);
        drive(8'h24, 8'h9E); step(3);
        drive(8'h24, 8'h02); step(3);
        drive(8'h24, 8'h9E);
        expect_commit(8'h21, 1'b1, 1'b0, 1'b0, 2'b00, 8'd0);
        step(8);

        // Blank + hex is BAD; byte_o keeps 21.
        drive(8'hFF, 8'h0C);
        expect_commit(8'h21, 1'b0, 1'b0, 1'b1, 2'b10, 8'd1);
        step(8);

        // clr pulse, then 8/8.
        drive(8'h00, 8'h00);
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        check("err_after_clr", 32'(err), 32'd0);
        expect_commit(8'h88, 1'b1, 1'b0, 1'b0, 2'b00, 8'd1);
        cyc_adjust_dummy();
        step(8);

        // Illegal low digit with clr on the commit edge: set must win.
        drive(8'h00, 8'hAA);
        expect_commit(8'h88, 1'b0, 1'b0, 1'b1, 2'b00, 8'd2);
        step(N - 1);
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        step(6);

        // 0/0, then dp-only changes on each digit.
        drive(8'h02, 8'h02);
        expect_commit(8'h00, 1'b1, 1'b0, 1'b1, 2'b00, 8'd2);
        step(7);
        drive(8'h02, 8'h03);
        expect_commit(8'h00, 1'b1, 1'b0, 1'b1, 2'b01, 8'd2);
        step(7);
        drive(8'h03, 8'h02);
        expect_commit(8'h00, 1'b1, 1'b0, 1'b1, 2'b10, 8'd2);
        step(7);

        // Reset at edge 2 of a 6/9 hold discards the count.
        drive(8'h40, 8'h08);
        step(1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check_reset("midrst");
        expect_commit(8'h69, 1'b1, 1'b0, 1'b0, 2'b00, 8'd0);
        step(8);

        // Back to blank: byte_o holds 69.
        drive(8'hFF, 8'hFF);
        expect_commit(8'h69, 1'b0, 1'b1, 1'b0, 2'b11, 8'd0);
        step(10);

        check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    // The 8/8 expectation is pushed one edge after the drive, so pull its deadline back by one.
    task automatic cyc_adjust_dummy();
        exp_t x;
        x = exp_q.pop_back();
        x.cyc = x.cyc - 1;
        exp_q.push_back(x);
    endtask

endmodule
